// File: rtl/dmi_pkg.sv
// Shared widths, DMI op codes, debug-module register map and abstract-command
// field helpers for the DM-side DMI endpoint.
package dmi_pkg;

    localparam int unsigned DMI_ADDR_WIDTH = 7;
    localparam int unsigned DMI_DATA_WIDTH = 32;
    localparam int unsigned DMI_OP_WIDTH   = 2;
    localparam int unsigned REQ_WIDTH      = DMI_ADDR_WIDTH + DMI_DATA_WIDTH + DMI_OP_WIDTH;
    localparam int unsigned RESP_WIDTH     = DMI_DATA_WIDTH + DMI_OP_WIDTH;

    localparam logic [DMI_OP_WIDTH-1:0] REQOP_NOP   = 2'd0;
    localparam logic [DMI_OP_WIDTH-1:0] REQOP_RD    = 2'd1;
    localparam logic [DMI_OP_WIDTH-1:0] REQOP_WR    = 2'd2;
    localparam logic [DMI_OP_WIDTH-1:0] RESPOP_OK   = 2'd0;
    localparam logic [DMI_OP_WIDTH-1:0] RESPOP_FAIL = 2'd2;

    localparam logic [DMI_ADDR_WIDTH-1:0] DM_DATA0      = 7'h04;
    localparam logic [DMI_ADDR_WIDTH-1:0] DM_DMCONTROL  = 7'h10;
    localparam logic [DMI_ADDR_WIDTH-1:0] DM_DMSTATUS   = 7'h11;
    localparam logic [DMI_ADDR_WIDTH-1:0] DM_ABSTRACTCS = 7'h16;
    localparam logic [DMI_ADDR_WIDTH-1:0] DM_COMMAND    = 7'h17;

    localparam logic [2:0] CMDERR_NONE       = 3'd0;
    localparam logic [2:0] CMDERR_BUSY       = 3'd1;
    localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
    localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;

    localparam int unsigned CMD_TYPE_MSB     = 31;
    localparam int unsigned CMD_TYPE_LSB     = 24;
    localparam int unsigned CMD_SIZE_MSB     = 22;
    localparam int unsigned CMD_SIZE_LSB     = 20;
    localparam int unsigned CMD_TRANSFER_BIT = 17;
    localparam int unsigned CMD_WRITE_BIT    = 16;
    localparam int unsigned CMD_REGNO_MSB    = 15;

    localparam logic [2:0]  CMD_SIZE_32      = 3'd2;
    localparam logic [15:0] GPR_REGNO_FIRST  = 16'h1000;
    localparam logic [15:0] GPR_REGNO_LAST   = 16'h101F;

    typedef enum logic {DIdle, DResp} dmi_state_e;
    typedef enum logic [1:0] {AIdle, AReq, AWait} abs_state_e;

    // Only 32-bit GPR transfers of access-register type are supported.
    function automatic logic cmd_unsupported(input logic [DMI_DATA_WIDTH-1:0] cmd);
        logic [15:0] regno;
        logic        xfer;
        regno = cmd[CMD_REGNO_MSB:0];
        xfer  = cmd[CMD_TRANSFER_BIT];
        return (cmd[CMD_TYPE_MSB:CMD_TYPE_LSB] != 8'd0) ||
               (xfer && (cmd[CMD_SIZE_MSB:CMD_SIZE_LSB] != CMD_SIZE_32)) ||
               (xfer && ((regno < GPR_REGNO_FIRST) || (regno > GPR_REGNO_LAST)));
    endfunction

endpackage

// File: rtl/dm_abs_cmd.sv
// Abstract-command executor: issues one GPR access on the hreg port and waits
// for its completion; abort returns it to idle and discards the completion.
module dm_abs_cmd
    import dmi_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        cmd_write_i,
    input  logic [4:0]  cmd_regno_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        busy_o,
    output logic        rdata_upd_o,
    output logic [31:0] rdata_o,
    output logic        hreg_req_vld_o,
    input  logic        hreg_rdy_i,
    output logic        hreg_wr_o,
    output logic [4:0]  hreg_addr_o,
    output logic [31:0] hreg_wdata_o,
    input  logic        hreg_rvld_i,
    input  logic [31:0] hreg_rdata_i
);

    abs_state_e  state_q, state_d;
    logic        wr_q, wr_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (abort_i) begin
            state_d = AIdle;
        end else begin
            unique case (state_q)
                AIdle: begin
                    if (start_i) begin
                        state_d = AReq;
                        wr_d    = cmd_write_i;
                        addr_d  = cmd_regno_i;
                        wdata_d = cmd_wdata_i;
                    end
                end
                AReq: begin
                    if (hreg_rdy_i) begin
                        state_d = AWait;
                    end
                end
                AWait: begin
                    if (hreg_rvld_i) begin
                        state_d = AIdle;
                    end
                end
                default: state_d = AIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= AIdle;
            wr_q    <= 1'b0;
            addr_q  <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Kept outside the FSM block so the parent's data0 path has no false loop.
    assign rdata_upd_o    = (state_q == AWait) && hreg_rvld_i && !abort_i && !wr_q;
    assign rdata_o        = hreg_rdata_i;
    assign busy_o         = (state_q != AIdle);
    assign hreg_req_vld_o = (state_q == AReq);
    assign hreg_wr_o      = wr_q;
    assign hreg_addr_o    = addr_q;
    assign hreg_wdata_o   = wdata_q;

endmodule

// File: rtl/dmi_dm_target.sv
// Debug-module end of the DMI link: one response per request, a minimal DM
// register set, and GPR abstract commands executed through dm_abs_cmd.
module dmi_dm_target
    import dmi_pkg::*;
(
    input  logic                  clk,
    input  logic                  dev_rst_n,
    input  logic                  req_vld,
    input  logic [REQ_WIDTH-1:0]  req_data,
    output logic                  req_rdy,
    output logic                  resp_vld,
    output logic [RESP_WIDTH-1:0] resp_data,
    input  logic                  resp_rdy,
    output logic                  haltreq,
    output logic                  resumereq,
    output logic                  ndmreset,
    input  logic                  hart_halted,
    output logic                  hreg_req_vld,
    input  logic                  hreg_rdy,
    output logic                  hreg_wr,
    output logic [4:0]            hreg_addr,
    output logic [31:0]           hreg_wdata,
    input  logic                  hreg_rvld,
    input  logic [31:0]           hreg_rdata
);

    dmi_state_e            dstate_q, dstate_d;
    logic [RESP_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  dmactive_q, dmactive_d;
    logic                  haltreq_q, haltreq_d;
    logic                  resumereq_q, resumereq_d;
    logic                  resumeack_q, resumeack_d;
    logic                  ndmreset_q, ndmreset_d;
    logic [31:0]           data0_q, data0_d;
    logic [2:0]            cmderr_q, cmderr_d;

    logic [DMI_ADDR_WIDTH-1:0] req_addr;
    logic [DMI_DATA_WIDTH-1:0] req_wdata;
    logic [DMI_OP_WIDTH-1:0]   req_op;
    logic                      is_wr;
    logic                      busy_target;
    logic [31:0]               rdata;
    logic                      abs_busy, abs_start, abs_upd;
    logic [31:0]               abs_rdata;

    assign {req_addr, req_wdata, req_op} = req_data;
    assign is_wr       = (dstate_q == DIdle) && req_vld && (req_op == REQOP_WR);
    assign busy_target = (req_addr == DM_DATA0) || (req_addr == DM_ABSTRACTCS) ||
                         (req_addr == DM_COMMAND);

    // dmactive is the only field a write can change while the DM is inactive.
    always_comb begin
        dmactive_d = dmactive_q;
        if (is_wr && (req_addr == DM_DMCONTROL)) begin
            dmactive_d = req_wdata[0];
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (req_addr)
            DM_DATA0:      rdata = data0_q;
            DM_DMCONTROL:  rdata = {haltreq_q, 1'b0, 28'd0, ndmreset_q, dmactive_q};
            DM_DMSTATUS:   rdata = {14'd0, {2{resumeack_q}}, 4'd0, {2{~hart_halted}},
                                    {2{hart_halted}}, 1'b1, 3'd0, 4'd2};
            DM_ABSTRACTCS: rdata = {3'd0, 5'd0, 11'd0, abs_busy, 1'b0, cmderr_q, 4'd0, 4'd1};
            default:       rdata = 32'd0;
        endcase
    end

    always_comb begin
        haltreq_d   = haltreq_q;
        resumereq_d = resumereq_q;
        resumeack_d = resumeack_q;
        ndmreset_d  = ndmreset_q;
        data0_d     = data0_q;
        cmderr_d    = cmderr_q;
        abs_start   = 1'b0;

        if (resumereq_q && !hart_halted) begin
            resumereq_d = 1'b0;
            resumeack_d = 1'b1;
        end
        if (abs_upd) begin
            data0_d = abs_rdata;
        end

        if (is_wr && dmactive_q) begin
            if (abs_busy && busy_target) begin
                if (cmderr_q == CMDERR_NONE) begin
                    cmderr_d = CMDERR_BUSY;
                end
            end else begin
                case (req_addr)
                    DM_DMCONTROL: begin
                        haltreq_d  = req_wdata[31];
                        ndmreset_d = req_wdata[1];
                        if (req_wdata[30] && !req_wdata[31]) begin
                            resumereq_d = 1'b1;
                            resumeack_d = 1'b0;
                        end
                    end
                    DM_DATA0:      data0_d  = req_wdata;
                    DM_ABSTRACTCS: cmderr_d = cmderr_q & ~req_wdata[10:8];
                    DM_COMMAND: begin
                        if (cmderr_q == CMDERR_NONE) begin
                            if (cmd_unsupported(req_wdata)) begin
                                cmderr_d = CMDERR_NOTSUP;
                            end else if (!hart_halted) begin
                                cmderr_d = CMDERR_HALTRESUME;
                            end else if (req_wdata[CMD_TRANSFER_BIT]) begin
                                abs_start = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (!dmactive_d) begin
            haltreq_d   = 1'b0;
            resumereq_d = 1'b0;
            resumeack_d = 1'b0;
            ndmreset_d  = 1'b0;
            data0_d     = 32'd0;
            cmderr_d    = CMDERR_NONE;
        end
    end

    always_comb begin
        dstate_d    = dstate_q;
        resp_data_d = resp_data_q;
        unique case (dstate_q)
            DIdle: begin
                if (req_vld) begin
                    dstate_d = DResp;
                    case (req_op)
                        REQOP_RD:           resp_data_d = {rdata, RESPOP_OK};
                        REQOP_NOP, REQOP_WR: resp_data_d = {32'd0, RESPOP_OK};
                        default:            resp_data_d = {32'd0, RESPOP_FAIL};
                    endcase
                end
            end
            DResp: begin
                if (resp_rdy) begin
                    dstate_d = DIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge dev_rst_n) begin
        if (!dev_rst_n) begin
            dstate_q    <= DIdle;
            resp_data_q <= '0;
            dmactive_q  <= 1'b0;
            haltreq_q   <= 1'b0;
            resumereq_q <= 1'b0;
            resumeack_q <= 1'b0;
            ndmreset_q  <= 1'b0;
            data0_q     <= 32'd0;
            cmderr_q    <= CMDERR_NONE;
        end else begin
            dstate_q    <= dstate_d;
            resp_data_q <= resp_data_d;
            dmactive_q  <= dmactive_d;
            haltreq_q   <= haltreq_d;
            resumereq_q <= resumereq_d;
            resumeack_q <= resumeack_d;
            ndmreset_q  <= ndmreset_d;
            data0_q     <= data0_d;
            cmderr_q    <= cmderr_d;
        end
    end

    dm_abs_cmd u_abs_cmd (
        .clk_i          (clk),
        .rst_ni         (dev_rst_n),
        .start_i        (abs_start),
        .abort_i        (~dmactive_d),
        .cmd_write_i    (req_wdata[CMD_WRITE_BIT]),
        .cmd_regno_i    (req_wdata[4:0]),
        .cmd_wdata_i    (data0_q),
        .busy_o         (abs_busy),
        .rdata_upd_o    (abs_upd),
        .rdata_o        (abs_rdata),
        .hreg_req_vld_o (hreg_req_vld),
        .hreg_rdy_i     (hreg_rdy),
        .hreg_wr_o      (hreg_wr),
        .hreg_addr_o    (hreg_addr),
        .hreg_wdata_o   (hreg_wdata),
        .hreg_rvld_i    (hreg_rvld),
        .hreg_rdata_i   (hreg_rdata)
    );

    assign req_rdy   = (dstate_q == DIdle);
    assign resp_vld  = (dstate_q == DResp);
    assign resp_data = resp_data_q;
    assign haltreq   = haltreq_q & dmactive_q;
    assign resumereq = resumereq_q;
    assign ndmreset  = ndmreset_q;

endmodule

// File: tb/tb_dmi_dm_target.sv
// Directed bench for dmi_dm_target: a transaction-level DM model checked every
// cycle, plus hand-computed literal expectations on key responses.
module tb_dmi_dm_target;
    import dmi_pkg::*;

    logic        clk = 1'b0;
    logic        dev_rst_n = 1'b0;
    logic        req_vld = 1'b0;
    logic [40:0] req_data = '0;
    logic        resp_rdy = 1'b1;
    logic        hart_halted = 1'b0;
    logic        hreg_rdy = 1'b0;
    logic        hreg_rvld = 1'b0;
    logic [31:0] hreg_rdata = '0;
    logic        req_rdy, resp_vld, haltreq, resumereq, ndmreset;
    logic        hreg_req_vld, hreg_wr;
    logic [33:0] resp_data;
    logic [4:0]  hreg_addr;
    logic [31:0] hreg_wdata;

    dmi_dm_target dut (
        .clk          (clk),
        .dev_rst_n    (dev_rst_n),
        .req_vld      (req_vld),
        .req_data     (req_data),
        .req_rdy      (req_rdy),
        .resp_vld     (resp_vld),
        .resp_data    (resp_data),
        .resp_rdy     (resp_rdy),
        .haltreq      (haltreq),
        .resumereq    (resumereq),
        .ndmreset     (ndmreset),
        .hart_halted  (hart_halted),
        .hreg_req_vld (hreg_req_vld),
        .hreg_rdy     (hreg_rdy),
        .hreg_wr      (hreg_wr),
        .hreg_addr    (hreg_addr),
        .hreg_wdata   (hreg_wdata),
        .hreg_rvld    (hreg_rvld),
        .hreg_rdata   (hreg_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_pend = 0;
    logic [33:0] m_resp = '0;
    bit          m_active = 0, m_halt = 0, m_ndm = 0, m_rreq = 0, m_rack = 0;
    logic [31:0] m_data0 = '0;
    logic [2:0]  m_err = '0;
    int          m_phase = 0;  // 0 no command, 1 offering to core, 2 awaiting completion
    bit          m_cwr = 0;
    logic [4:0]  m_creg = '0;
    logic [31:0] m_cwd = '0;
    logic [6:0]  m_a;
    logic [31:0] m_d, m_rd;
    logic [1:0]  m_op;
    bit          m_accept, m_was_busy;

    function automatic logic [31:0] m_read(input logic [6:0] a);
        case (a)
            7'h04: return m_data0;
            7'h10: return (32'(m_halt) << 31) + (32'(m_ndm) << 1) + 32'(m_active);
            7'h11: return 32'h82 + (hart_halted ? 32'h300 : 32'hC00) + (m_rack ? 32'h30000 : 0);
            7'h16: return 32'h1 + (32'(m_err) << 8) + ((m_phase != 0) ? 32'h1000 : 0);
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_clear();
        m_halt = 0; m_ndm = 0; m_rreq = 0; m_rack = 0;
        m_data0 = '0; m_err = '0; m_phase = 0;
    endtask

    task automatic m_write(input logic [6:0] a, input logic [31:0] d, input bit busy);
        if (!m_active) begin
            if (a == 7'h10) m_active = d[0];
            return;
        end
        if (busy && (a == 7'h04 || a == 7'h16 || a == 7'h17)) begin
            if (m_err == 0) m_err = 3'd1;
            return;
        end
        case (a)
            7'h10: begin
                m_halt = d[31]; m_ndm = d[1]; m_active = d[0];
                if (d[30] && !d[31]) begin m_rreq = 1; m_rack = 0; end
            end
            7'h04: m_data0 = d;
            7'h16: m_err = m_err & ~d[10:8];
            7'h17: begin
                if (m_err == 0) begin
                    if (d[31:24] != 0 || (d[17] && (d[22:20] != 3'd2 ||
                        d[15:0] < 16'h1000 || d[15:0] > 16'h101F))) m_err = 3'd2;
                    else if (!hart_halted) m_err = 3'd4;
                    else if (d[17]) begin
                        m_phase = 1; m_cwr = d[16]; m_creg = d[4:0]; m_cwd = m_data0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge dev_rst_n) begin
        if (!dev_rst_n) begin
            m_pend = 0; m_resp = '0; m_active = 0;
            m_clear();
        end else begin
            m_was_busy = (m_phase != 0);
            {m_a, m_d, m_op} = req_data;
            m_accept = !m_pend && req_vld;
            m_rd = m_read(m_a);
            if (m_pend && resp_rdy) m_pend = 0;
            if (m_rreq && !hart_halted) begin m_rreq = 0; m_rack = 1; end
            if (m_phase == 1 && hreg_rdy) m_phase = 2;
            else if (m_phase == 2 && hreg_rvld) begin
                if (!m_cwr) m_data0 = hreg_rdata;
                m_phase = 0;
            end
            if (m_accept) begin
                m_pend = 1;
                m_resp = (m_op == 2'd3) ? 34'h2 : (m_op == 2'd1) ? {m_rd, 2'b00} : 34'h0;
                if (m_op == 2'd2) m_write(m_a, m_d, m_was_busy);
            end
            if (!m_active) m_clear();
        end
    end

    always @(negedge clk) begin
        chk("req_rdy", req_rdy, !m_pend);
        chk("resp_vld", resp_vld, m_pend);
        if (m_pend) chk("resp_data", resp_data, m_resp);
        chk("haltreq", haltreq, m_halt & m_active);
        chk("resumereq", resumereq, m_rreq);
        chk("ndmreset", ndmreset, m_ndm);
        chk("hreg_req_vld", hreg_req_vld, m_phase == 1);
        if (m_phase == 1) begin
            chk("hreg_wr", hreg_wr, m_cwr);
            chk("hreg_addr", hreg_addr, m_creg);
            chk("hreg_wdata", hreg_wdata, m_cwd);
        end
    end

    // ---------------- core GPR port responder ----------------
    bit          core_en = 1;
    int          core_lat = 3;
    int          core_cnt = 0;
    logic [31:0] core_rdata = '0;

    initial forever begin
        @(posedge clk); #1;
        hreg_rvld = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                hreg_rvld = 1'b1;
                hreg_rdata = core_rdata;
            end
        end
        hreg_rdy = hreg_req_vld && core_en && (core_cnt == 0);
        if (hreg_rdy) core_cnt = core_lat;
    end

    // ---------------- stimulus ----------------
    task automatic dmi(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op,
                       input int hold, output logic [33:0] resp);
        int n;
        resp = '0;
        resp_rdy = (hold == 0);
        req_data = {a, d, op};
        req_vld = 1'b1;
        n = 0;
        while (!req_rdy && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_vld = 1'b0;
        chk("resp_latency1", resp_vld, 1'b1);
        repeat (hold) begin @(posedge clk); #1; end
        if (hold > 0) chk("resp_held", resp_vld, 1'b1);
        resp = resp_data;
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        chk("resp_retired", resp_vld, 1'b0);
    endtask

    function automatic logic [33:0] rd_ok(input logic [31:0] v);
        return {v, 2'b00};
    endfunction

    logic [33:0] r;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_rdy", req_rdy, 1'b1);
        chk("rst_resp_vld", resp_vld, 1'b0);
        chk("rst_resp_data", resp_data, 34'h0);
        chk("rst_hreg_addr", {hreg_req_vld, hreg_wr, hreg_addr}, 7'h0);
        chk("rst_hreg_wdata", hreg_wdata, 32'h0);
        dev_rst_n = 1'b1;
        @(posedge clk); #1;

        dmi(7'h10, 32'h1, 2'd2, 0, r);
        chk("wr_dmcontrol_resp", r, 34'h0);
        dmi(7'h11, 32'h0, 2'd1, 3, r);
        chk("dmstatus_running", r, rd_ok(32'h00000C82));

        dmi(7'h10, 32'h80000001, 2'd2, 0, r);
        chk("haltreq_set", haltreq, 1'b1);
        hart_halted = 1'b1;
        dmi(7'h11, 32'h0, 2'd1, 0, r);
        chk("dmstatus_halted", r, rd_ok(32'h00000382));

        core_lat = 3; core_rdata = 32'hDEADBEEF;
        dmi(7'h17, 32'h00221005, 2'd2, 0, r);
        dmi(7'h16, 32'h0, 2'd1, 0, r);
        chk("abstractcs_busy", r, rd_ok(32'h00001001));
        repeat (5) @(posedge clk); #1;
        dmi(7'h04, 32'h0, 2'd1, 0, r);
        chk("data0_from_gpr", r, rd_ok(32'hDEADBEEF));
        dmi(7'h16, 32'h0, 2'd1, 0, r);
        chk("abstractcs_done", r, rd_ok(32'h00000001));

        core_lat = 8; core_rdata = 32'h12345678;
        dmi(7'h17, 32'h00221005, 2'd2, 0, r);
        dmi(7'h17, 32'h00221006, 2'd2, 0, r);
        repeat (12) @(posedge clk); #1;
        dmi(7'h17, 32'h00221005, 2'd2, 0, r);
        chk("cmd_ignored_noreq", hreg_req_vld, 1'b0);
        dmi(7'h16, 32'h0, 2'd1, 0, r);
        chk("cmderr_busy", r, rd_ok(32'h00000101));
        dmi(7'h04, 32'h0, 2'd1, 0, r);
        chk("data0_first_cmd", r, rd_ok(32'h12345678));
        dmi(7'h16, 32'h700, 2'd2, 0, r);
        dmi(7'h16, 32'h0, 2'd1, 0, r);
        chk("cmderr_cleared", r, rd_ok(32'h00000001));

        hart_halted = 1'b0;
        dmi(7'h17, 32'h00221005, 2'd2, 0, r);
        chk("running_noreq", hreg_req_vld, 1'b0);
        dmi(7'h16, 32'h0, 2'd1, 0, r);
        chk("cmderr_haltresume", r, rd_ok(32'h00000401));
        dmi(7'h16, 32'h700, 2'd2, 0, r);
        hart_halted = 1'b1;
        dmi(7'h17, 32'h00321005, 2'd2, 0, r);
        dmi(7'h16, 32'h0, 2'd1, 0, r);
        chk("cmderr_notsup", r, rd_ok(32'h00000201));
        dmi(7'h16, 32'h700, 2'd2, 0, r);
        dmi(7'h17, 32'h00201005, 2'd2, 0, r);
        dmi(7'h16, 32'h0, 2'd1, 0, r);
        chk("no_transfer_idle", r, rd_ok(32'h00000001));

        dmi(7'h04, 32'hCAFEF00D, 2'd2, 0, r);
        core_en = 0; core_lat = 2;
        dmi(7'h17, 32'h00231007, 2'd2, 0, r);
        chk("gpr_wr_req", {hreg_req_vld, hreg_wr, hreg_addr}, {1'b1, 1'b1, 5'd7});
        chk("gpr_wr_data", hreg_wdata, 32'hCAFEF00D);
        core_en = 1;
        repeat (6) @(posedge clk); #1;
        dmi(7'h04, 32'h0, 2'd1, 0, r);
        chk("data0_after_gpr_wr", r, rd_ok(32'hCAFEF00D));

        core_lat = 10; core_rdata = 32'h0BADF00D;
        dmi(7'h17, 32'h00221005, 2'd2, 0, r);
        dmi(7'h10, 32'h0, 2'd2, 0, r);
        chk("abort_noreq", hreg_req_vld, 1'b0);
        dmi(7'h10, 32'h1, 2'd2, 0, r);
        repeat (14) @(posedge clk); #1;
        dmi(7'h04, 32'h0, 2'd1, 0, r);
        chk("abort_data0", r, rd_ok(32'h0));
        dmi(7'h16, 32'h0, 2'd1, 0, r);
        chk("abort_abstractcs", r, rd_ok(32'h00000001));

        dmi(7'h10, 32'h40000001, 2'd2, 0, r);
        chk("resumereq_set", resumereq, 1'b1);
        hart_halted = 1'b0;
        @(posedge clk); #1;
        chk("resumereq_cleared", resumereq, 1'b0);
        dmi(7'h11, 32'h0, 2'd1, 0, r);
        chk("dmstatus_resumeack", r, rd_ok(32'h00030C82));

        dmi(7'h04, 32'h11111111, 2'd3, 0, r);
        chk("op3_fail", r, 34'h2);
        dmi(7'h04, 32'h0, 2'd0, 0, r);
        chk("nop_resp", r, 34'h0);

        resp_rdy = 1'b0;
        req_data = {7'h11, 32'h0, 2'd1};
        req_vld = 1'b1;
        @(posedge clk); #1;
        req_vld = 1'b0;
        chk("pre_reset_resp_vld", resp_vld, 1'b1);
        #2 dev_rst_n = 1'b0;
        #1;
        chk("reset_drops_resp", resp_vld, 1'b0);
        chk("reset_req_rdy", req_rdy, 1'b1);
        @(posedge clk); #1;
        dev_rst_n = 1'b1;
        resp_rdy = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("post_reset_idle", resp_vld, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmi_dm_target.md
Name: dmi_dm_target

Overview:
- Debug-module-side endpoint of the DMI link. It consumes DMI requests of the form {addr[6:0], data[31:0], op[1:0]} and returns responses of the form {data[31:0], op[1:0]}.
- Implements a minimal RISC-V debug-module register set: data0, dmcontrol, dmstatus, abstractcs and command.
- Executes abstract GPR access commands against the core through a simple request/response register port.
- Lives in the core clock domain, behind the JTAG-DMI interconnect/CDC.

Parameters:
- DMI_ADDR_WIDTH, 7, DMI address bits.
- DMI_DATA_WIDTH, 32, DMI data bits.
- DMI_OP_WIDTH, 2, DMI op/status bits.
- REQ_WIDTH, ADDR+DATA+OP (41), request bus width.
- RESP_WIDTH, DATA+OP (34), response bus width.

Ports:
- clk  in  1  core clock
- dev_rst_n  in  1  asynchronous active-low reset
- req_vld  in  1  DMI request valid
- req_data  in  REQ_WIDTH  {addr, data, op}; op: 0 nop, 1 read, 2 write, 3 reserved
- req_rdy  out  1  request ready
- resp_vld  out  1  response valid
- resp_data  out  RESP_WIDTH  {data, op}; op: 0 success, 2 failed
- resp_rdy  in  1  response accepted
- haltreq  out  1  halt request to hart
- resumereq  out  1  resume request to hart
- ndmreset  out  1  non-debug-module reset
- hart_halted  in  1  hart halted status
- hreg_req_vld  out  1  GPR access request
- hreg_rdy  in  1  core accepts GPR request
- hreg_wr  out  1  1 = write GPR
- hreg_addr  out  5  GPR index
- hreg_wdata  out  32  GPR write data
- hreg_rvld  in  1  GPR access complete; read data valid
- hreg_rdata  in  32  GPR read data

Behaviour:
- Reset (async, dev_rst_n=0):
  - req_rdy=1; resp_vld=0; resp_data=0.
  - haltreq, resumereq, ndmreset, hreg_req_vld, hreg_wr = 0; hreg_addr, hreg_wdata = 0.
  - All registers 0 and both FSMs idle.
  - Reset mid-transaction drops any pending response and command.
- DMI FSM, states D_IDLE and D_RESP:
  - D_IDLE: req_rdy=1. On req_vld, latch the request, perform the register access, load resp_data, go to D_RESP. resp_vld is asserted the cycle after acceptance (latency 1).
  - D_RESP: req_rdy=0 and resp_vld=1; resp_data is held stable until resp_rdy. On resp_vld & resp_rdy, go to D_IDLE.
  - Exactly one response per accepted request.
  - op 0 (nop): response {0, 0}. op 3: response {0, 2}, no side effects. Read/write: op 0.
- Registers (addresses hex):
  - 0x10 dmcontrol
    - Fields: [31] haltreq, [30] resumereq (write-only, reads 0), [1] ndmreset, [0] dmactive.
    - While dmactive=0, writes update dmactive only. All other DM state is held at reset values, except that ndmreset is also forced 0.
  - 0x04 data0: RW.
  - 0x11 dmstatus: RO.
    - [3:0]=2; [7]=1 authenticated.
    - [9:8] = {2{hart_halted}}; [11:10] = {2{~hart_halted}}; [17:16] = {2{resumeack}}.
  - 0x16 abstractcs
    - Fields: [3:0]=1 datacount, [10:8] cmderr (W1C per bit), [12] busy, [28:24]=0.
  - 0x17 command: write launches a command; reads return 0.
  - Other addresses: read returns 0; write is ignored; op 0.
- Resume:
  - Writing resumereq=1 with haltreq=0 sets resumereq and clears resumeack.
  - The first cycle with hart_halted=0 while resumereq=1 clears resumereq and sets resumeack (sticky).
  - haltreq output = dmcontrol.haltreq & dmactive.
- Abstract command
  - Fields: cmdtype [31:24], aarsize [22:20], transfer [17], write [16], regno [15:0].
  - Busy writes: a write to command, data0 or abstractcs while busy sets cmderr=1 (if cmderr is 0) and is ignored.
  - Error checks: if cmderr!=0, the command write is ignored. Otherwise, checked in order:
    - cmdtype!=0, or aarsize!=2 while transfer=1, or transfer=1 with regno outside 0x1000..0x101F → cmderr=2.
    - hart_halted=0 → cmderr=4.
    - transfer=0 → completes immediately, no busy.
  - Execution:
    - A_REQ: hreg_req_vld held with stable hreg_wr=write, hreg_addr=regno[4:0], hreg_wdata=data0 until hreg_rdy. Then A_WAIT until hreg_rvld.
    - On hreg_rvld: data0 <= hreg_rdata if write=0; busy clears.
    - busy=1 from the cycle after the command write through the hreg_rvld cycle.
  - Clearing dmactive aborts the command: FSM goes to idle, hreg_req_vld=0, and later hreg_rvld is ignored.

Decomposition:
- Package dmi_pkg holds:
  - Width constants.
  - DMI op codes: REQOP_NOP/RD/WR, RESPOP_OK/FAIL.
  - Register addresses DM_DATA0/DMCONTROL/DMSTATUS/ABSTRACTCS/COMMAND.
  - cmderr codes NONE=0, BUSY=1, NOTSUP=2, HALTRESUME=4.
  - Command field positions.
- One sub-module, dm_abs_cmd: the abstract-command FSM (A_IDLE/A_REQ/A_WAIT) plus the hreg port.

Test Plan:
- Write 0x10 data 0x1, then read 0x11 with hart_halted=0 → resp {0x00000C82, 0}; resp_vld appears 1 cycle after acceptance and holds 3 cycles under resp_rdy=0.
- Write 0x80000001 to 0x10 → haltreq=1; set hart_halted=1; read 0x11 → bits [9:8]=11.
- Halted hart, command 0x00221005 (read x5), core returns 0xDEADBEEF after 3 cycles → abstractcs.busy=1 meanwhile; then data0 reads 0xDEADBEEF and cmderr=0.
- Command while busy → cmderr=1. Next command ignored. Write 0x700 to 0x16 → cmderr=0.
- Command with hart_halted=0 → cmderr=4, no hreg_req_vld. aarsize=3 → cmderr=2.
- Request op 3 → resp {0, 2}. Assert dev_rst_n=0 during D_RESP → resp_vld=0 immediately, req_rdy=1.
